// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: opcodes, memory-access
// encodings, the EX register layout and its bubble value.
package id_ex_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] READ_MEM_NONE = 3'b000;
    localparam logic [2:0] READ_MEM_LW   = 3'b001;
    localparam logic [2:0] READ_MEM_LH   = 3'b010;
    localparam logic [2:0] READ_MEM_LHU  = 3'b011;
    localparam logic [2:0] READ_MEM_LB   = 3'b100;
    localparam logic [2:0] READ_MEM_LBU  = 3'b101;

    localparam logic [1:0] WRITE_MEM_NONE = 2'b00;
    localparam logic [1:0] WRITE_MEM_SW   = 2'b01;
    localparam logic [1:0] WRITE_MEM_SH   = 2'b10;
    localparam logic [1:0] WRITE_MEM_SB   = 2'b11;

    localparam logic [15:0] BUBBLE_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_LOAD
    } ex_action_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm32;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  aluc;
        logic        aluOut_WB_memOut;
        logic        rs1Data_EX_PC;
        logic [1:0]  rs2Data_EX_imm32_4;
        logic        write_reg;
        logic [1:0]  write_mem;
        logic [2:0]  read_mem;
        logic [1:0]  pcImm_NEXTPC_rs1Imm;
    } ex_reg_t;

    localparam ex_reg_t EX_BUBBLE = '{
        valid:               1'b0,
        pc:                  32'h0,
        rs1_data:            32'h0,
        rs2_data:            32'h0,
        imm32:               32'h0,
        rs1:                 5'd0,
        rs2:                 5'd0,
        rd:                  5'd0,
        aluc:                5'd0,
        aluOut_WB_memOut:    1'b0,
        rs1Data_EX_PC:       1'b0,
        rs2Data_EX_imm32_4:  2'b00,
        write_reg:           1'b0,
        write_mem:           WRITE_MEM_NONE,
        read_mem:            READ_MEM_NONE,
        pcImm_NEXTPC_rs1Imm: 2'b00
    };

    // Upper-immediate and JAL encode immediate bits where rs1 would sit.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side bundle entering the ID/EX register and the registered EX-side copy.
interface id_ex_stage_if;

    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm32;
    logic [4:0]  id_aluc;
    logic        id_aluOut_WB_memOut;
    logic        id_rs1Data_EX_PC;
    logic [1:0]  id_rs2Data_EX_imm32_4;
    logic        id_write_reg;
    logic [1:0]  id_write_mem;
    logic [2:0]  id_read_mem;
    logic [1:0]  id_pcImm_NEXTPC_rs1Imm;

    logic        ex_valid;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm32;
    logic [4:0]  ex_aluc;
    logic        ex_aluOut_WB_memOut;
    logic        ex_rs1Data_EX_PC;
    logic [1:0]  ex_rs2Data_EX_imm32_4;
    logic        ex_write_reg;
    logic [1:0]  ex_write_mem;
    logic [2:0]  ex_read_mem;
    logic [1:0]  ex_pcImm_NEXTPC_rs1Imm;

    modport master (
        output id_opcode, id_rs1, id_rs2, id_rd, id_pc, id_rs1_data, id_rs2_data,
               id_imm32, id_aluc, id_aluOut_WB_memOut, id_rs1Data_EX_PC,
               id_rs2Data_EX_imm32_4, id_write_reg, id_write_mem, id_read_mem,
               id_pcImm_NEXTPC_rs1Imm,
        input  ex_valid, ex_rs1, ex_rs2, ex_rd, ex_pc, ex_rs1_data, ex_rs2_data,
               ex_imm32, ex_aluc, ex_aluOut_WB_memOut, ex_rs1Data_EX_PC,
               ex_rs2Data_EX_imm32_4, ex_write_reg, ex_write_mem, ex_read_mem,
               ex_pcImm_NEXTPC_rs1Imm
    );

    modport slave (
        input  id_opcode, id_rs1, id_rs2, id_rd, id_pc, id_rs1_data, id_rs2_data,
               id_imm32, id_aluc, id_aluOut_WB_memOut, id_rs1Data_EX_PC,
               id_rs2Data_EX_imm32_4, id_write_reg, id_write_mem, id_read_mem,
               id_pcImm_NEXTPC_rs1Imm,
        output ex_valid, ex_rs1, ex_rs2, ex_rd, ex_pc, ex_rs1_data, ex_rs2_data,
               ex_imm32, ex_aluc, ex_aluOut_WB_memOut, ex_rs1Data_EX_PC,
               ex_rs2Data_EX_imm32_4, ex_write_reg, ex_write_mem, ex_read_mem,
               ex_pcImm_NEXTPC_rs1Imm
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction currently in ID.
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic [2:0] ex_read_mem,
    input  logic       ex_write_reg,
    input  logic [4:0] ex_rd,
    output logic       hazard
);

    logic ex_is_load_to_reg;
    logic rs1_conflict;
    logic rs2_conflict;

    // x0 is hard-wired, so a load targeting it can never feed a dependent.
    assign ex_is_load_to_reg = ex_valid
                             & (ex_read_mem != READ_MEM_NONE)
                             & ex_write_reg
                             & (ex_rd != 5'd0);

    assign rs1_conflict = uses_rs1(id_opcode) & (id_rs1 == ex_rd);
    assign rs2_conflict = uses_rs2(id_opcode) & (id_rs2 == ex_rd);

    assign hazard = ex_is_load_to_reg & (rs1_conflict | rs2_conflict);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hold/flush/bubble/load priority, load-use
// stall generation and a saturating bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus,
    input  logic         flush_i,
    input  logic         mem_busy_i,
    output logic         stall_o,
    output logic [15:0]  bubble_cnt
);

    ex_reg_t     ex_q;
    ex_reg_t     id_rec;
    ex_action_e  action;
    logic        hazard;
    logic [15:0] bubble_cnt_q;

    always_comb begin
        id_rec                     = EX_BUBBLE;
        id_rec.valid               = 1'b1;
        id_rec.pc                  = bus.id_pc;
        id_rec.rs1_data            = bus.id_rs1_data;
        id_rec.rs2_data            = bus.id_rs2_data;
        id_rec.imm32               = bus.id_imm32;
        id_rec.rs1                 = bus.id_rs1;
        id_rec.rs2                 = bus.id_rs2;
        id_rec.rd                  = bus.id_rd;
        id_rec.aluc                = bus.id_aluc;
        id_rec.aluOut_WB_memOut    = bus.id_aluOut_WB_memOut;
        id_rec.rs1Data_EX_PC       = bus.id_rs1Data_EX_PC;
        id_rec.rs2Data_EX_imm32_4  = bus.id_rs2Data_EX_imm32_4;
        id_rec.write_reg           = bus.id_write_reg;
        id_rec.write_mem           = bus.id_write_mem;
        id_rec.read_mem            = bus.id_read_mem;
        id_rec.pcImm_NEXTPC_rs1Imm = bus.id_pcImm_NEXTPC_rs1Imm;
    end

    hazard_detect u_hazard_detect (
        .id_opcode    (bus.id_opcode),
        .id_rs1       (bus.id_rs1),
        .id_rs2       (bus.id_rs2),
        .ex_valid     (ex_q.valid),
        .ex_read_mem  (ex_q.read_mem),
        .ex_write_reg (ex_q.write_reg),
        .ex_rd        (ex_q.rd),
        .hazard       (hazard)
    );

    // A pending redirect kills the ID instruction, so it must not also stall it.
    always_comb begin
        if (mem_busy_i) begin
            action = ACT_HOLD;
        end else if (flush_i) begin
            action = ACT_FLUSH;
        end else if (hazard) begin
            action = ACT_BUBBLE;
        end else begin
            action = ACT_LOAD;
        end
    end

    assign stall_o = mem_busy_i | (hazard & ~flush_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q         <= EX_BUBBLE;
            bubble_cnt_q <= '0;
        end else begin
            case (action)
                ACT_HOLD: begin
                    ex_q <= ex_q;
                end
                ACT_FLUSH: begin
                    ex_q <= EX_BUBBLE;
                end
                ACT_BUBBLE: begin
                    ex_q <= EX_BUBBLE;
                    if (bubble_cnt_q != BUBBLE_CNT_MAX) begin
                        bubble_cnt_q <= bubble_cnt_q + 16'd1;
                    end
                end
                default: begin
                    ex_q <= id_rec;
                end
            endcase
        end
    end

    assign bubble_cnt                 = bubble_cnt_q;
    assign bus.ex_valid               = ex_q.valid;
    assign bus.ex_pc                  = ex_q.pc;
    assign bus.ex_rs1_data            = ex_q.rs1_data;
    assign bus.ex_rs2_data            = ex_q.rs2_data;
    assign bus.ex_imm32               = ex_q.imm32;
    assign bus.ex_rs1                 = ex_q.rs1;
    assign bus.ex_rs2                 = ex_q.rs2;
    assign bus.ex_rd                  = ex_q.rd;
    assign bus.ex_aluc                = ex_q.aluc;
    assign bus.ex_aluOut_WB_memOut    = ex_q.aluOut_WB_memOut;
    assign bus.ex_rs1Data_EX_PC       = ex_q.rs1Data_EX_PC;
    assign bus.ex_rs2Data_EX_imm32_4  = ex_q.rs2Data_EX_imm32_4;
    assign bus.ex_write_reg           = ex_q.write_reg;
    assign bus.ex_write_mem           = ex_q.write_mem;
    assign bus.ex_read_mem            = ex_q.read_mem;
    assign bus.ex_pcImm_NEXTPC_rs1Imm = ex_q.pcImm_NEXTPC_rs1Imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized bench for id_ex_stage against a cycle-level model
// of the pipeline-register rules.
module tb_id_ex_stage;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm32;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  aluc;
        logic        alu_wb;
        logic        rs1_sel;
        logic [1:0]  rs2_sel;
        logic        write_reg;
        logic [1:0]  write_mem;
        logic [2:0]  read_mem;
        logic [1:0]  next_sel;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        mem_busy_i;
    logic        stall_o;
    logic [15:0] bubble_cnt;

    rec_t        dut_rec;
    rec_t        exp_rec;
    rec_t        id_rec;
    logic [6:0]  id_op;
    int          exp_cnt;
    int          checks;
    int          errors;
    logic [6:0]  ops [9] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP};

    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .flush_i    (flush_i),
        .mem_busy_i (mem_busy_i),
        .stall_o    (stall_o),
        .bubble_cnt (bubble_cnt)
    );

    assign dut_rec = {bus.ex_valid, bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm32,
                      bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_aluc, bus.ex_aluOut_WB_memOut,
                      bus.ex_rs1Data_EX_PC, bus.ex_rs2Data_EX_imm32_4, bus.ex_write_reg,
                      bus.ex_write_mem, bus.ex_read_mem, bus.ex_pcImm_NEXTPC_rs1Imm};

    function automatic bit reads_rs1(input logic [6:0] op);
        return !(op inside {LUI, AUIPC, JAL});
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {OP, STORE, BRANCH};
    endfunction

    // A load in EX whose result the ID instruction wants, ignoring x0.
    function automatic bit model_hazard();
        bit dep;
        dep = (reads_rs1(id_op) && id_rec.rs1 == exp_rec.rd) ||
              (reads_rs2(id_op) && id_rec.rs2 == exp_rec.rd);
        return exp_rec.valid && exp_rec.read_mem != 3'd0 && exp_rec.write_reg &&
               exp_rec.rd != 5'd0 && dep;
    endfunction

    task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] rm, input logic wr,
                                 input logic fl, input logic busy);
        id_op            = op;
        id_rec.valid     = 1'b1;
        id_rec.pc        = $urandom;
        id_rec.rs1_data  = $urandom;
        id_rec.rs2_data  = $urandom;
        id_rec.imm32     = $urandom;
        id_rec.rs1       = rs1;
        id_rec.rs2       = rs2;
        id_rec.rd        = rd;
        id_rec.aluc      = 5'($urandom_range(0, 31));
        id_rec.alu_wb    = 1'($urandom_range(0, 1));
        id_rec.rs1_sel   = 1'($urandom_range(0, 1));
        id_rec.rs2_sel   = 2'($urandom_range(0, 3));
        id_rec.write_reg = wr;
        id_rec.write_mem = (op == STORE) ? 2'($urandom_range(1, 3)) : 2'd0;
        id_rec.read_mem  = rm;
        id_rec.next_sel  = 2'($urandom_range(0, 3));
        bus.id_opcode              = op;
        bus.id_pc                  = id_rec.pc;
        bus.id_rs1_data            = id_rec.rs1_data;
        bus.id_rs2_data            = id_rec.rs2_data;
        bus.id_imm32               = id_rec.imm32;
        bus.id_rs1                 = id_rec.rs1;
        bus.id_rs2                 = id_rec.rs2;
        bus.id_rd                  = id_rec.rd;
        bus.id_aluc                = id_rec.aluc;
        bus.id_aluOut_WB_memOut    = id_rec.alu_wb;
        bus.id_rs1Data_EX_PC       = id_rec.rs1_sel;
        bus.id_rs2Data_EX_imm32_4  = id_rec.rs2_sel;
        bus.id_write_reg           = id_rec.write_reg;
        bus.id_write_mem           = id_rec.write_mem;
        bus.id_read_mem            = id_rec.read_mem;
        bus.id_pcImm_NEXTPC_rs1Imm = id_rec.next_sel;
        flush_i    = fl;
        mem_busy_i = busy;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (dut_rec === exp_rec) else begin
            errors++;
            $error("[TB] FAIL %s ex_reg: observed %h expected %h", tag, dut_rec, exp_rec);
        end
        checks++;
        assert (bubble_cnt === 16'(exp_cnt)) else begin
            errors++;
            $error("[TB] FAIL %s bubble_cnt: observed %h expected %h", tag, bubble_cnt, 16'(exp_cnt));
        end
    endtask

    task automatic checkStall(input string tag, input logic expected);
        checks++;
        assert (stall_o === expected) else begin
            errors++;
            $error("[TB] FAIL %s stall_o: observed %b expected %b", tag, stall_o, expected);
        end
    endtask

    // Starts at a falling edge with inputs applied, ends at the next falling edge.
    task automatic cycle(input string tag);
        bit hz;
        #1;
        hz = model_hazard();
        checkStall(tag, mem_busy_i | (hz & ~flush_i));
        @(posedge clk);
        if (!mem_busy_i) begin
            if (flush_i) begin
                exp_rec = '0;
            end else if (hz) begin
                exp_rec = '0;
                exp_cnt = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
            end else begin
                exp_rec = id_rec;
            end
        end
        #1;
        checkOutput(tag);
        @(negedge clk);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b1;
        exp_rec = '0;
        exp_cnt = 0;
        applyStimulus(OP, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);

        #2 rst_n = 1'b0;
        #1 checkOutput("reset_async");
        mem_busy_i = 1'b1;
        #1 checkStall("reset_stall_busy", 1'b1);
        mem_busy_i = 1'b0;
        #1 checkStall("reset_stall_idle", 1'b0);
        @(posedge clk);
        #1 checkOutput("reset_held");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(LOAD, 5'd5, 5'd2, 5'd0, 3'b001, 1'b1, 1'b0, 1'b0);
        cycle("lw_x5_load");
        applyStimulus(OP, 5'd6, 5'd5, 5'd1, 3'd0, 1'b1, 1'b0, 1'b0);
        cycle("add_rs1_bubble");
        checks++;
        assert (bus.ex_valid === 1'b0 && bubble_cnt === 16'd1) else begin
            errors++;
            $error("[TB] FAIL loaduse_bubble valid/cnt: observed %b/%0d expected 0/1", bus.ex_valid, bubble_cnt);
        end
        cycle("add_loads_after");

        applyStimulus(LOAD, 5'd5, 5'd3, 5'd0, 3'b001, 1'b1, 1'b0, 1'b0);
        cycle("lw_x5_again");
        applyStimulus(LUI, 5'd5, 5'd5, 5'd5, 3'd0, 1'b1, 1'b0, 1'b0);
        cycle("lui_no_hazard");

        applyStimulus(LOAD, 5'd7, 5'd3, 5'd0, 3'b010, 1'b1, 1'b0, 1'b0);
        cycle("lh_x7");
        applyStimulus(STORE, 5'd0, 5'd1, 5'd7, 3'd0, 1'b0, 1'b0, 1'b0);
        cycle("sw_rs2_bubble");
        cycle("sw_loads_after");

        applyStimulus(LOAD, 5'd9, 5'd3, 5'd0, 3'b001, 1'b1, 1'b0, 1'b0);
        cycle("lw_x9");
        applyStimulus(OP_IMM, 5'd4, 5'd1, 5'd9, 3'd0, 1'b1, 1'b0, 1'b0);
        cycle("opimm_rs2_unused");

        applyStimulus(LOAD, 5'd0, 5'd3, 5'd0, 3'b001, 1'b1, 1'b0, 1'b0);
        cycle("lw_x0");
        applyStimulus(OP, 5'd4, 5'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        cycle("rd0_no_hazard");

        applyStimulus(LOAD, 5'd5, 5'd3, 5'd0, 3'b001, 1'b1, 1'b0, 1'b0);
        cycle("lw_x5_pre_flush");
        applyStimulus(OP, 5'd6, 5'd5, 5'd1, 3'd0, 1'b1, 1'b1, 1'b0);
        cycle("flush_beats_hazard");

        applyStimulus(JAL, 5'd1, 5'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        cycle("jal_load");
        applyStimulus(OP, 5'd8, 5'd1, 5'd2, 3'd0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle("busy_holds_flush");
        mem_busy_i = 1'b0;
        cycle("flush_accepted");

        applyStimulus(LOAD, 5'd5, 5'd3, 5'd0, 3'b001, 1'b1, 1'b0, 1'b0);
        cycle("lw_pre_busy");
        applyStimulus(BRANCH, 5'd0, 5'd2, 5'd5, 3'd0, 1'b0, 1'b0, 1'b1);
        cycle("busy_with_hazard");
        mem_busy_i = 1'b0;
        cycle("branch_bubble");
        cycle("branch_loads");

        applyStimulus(OP, 5'd10, 5'd1, 5'd2, 3'd0, 1'b1, 1'b0, 1'b0);
        cycle("pre_reset_load");
        #2 rst_n = 1'b0;
        exp_rec = '0;
        exp_cnt = 0;
        #1 checkOutput("midstream_reset");
        checkStall("midstream_reset_stall", 1'b0);
        @(posedge clk);
        #1 checkOutput("midstream_reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(AUIPC, 5'd11, 5'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        cycle("resume_load");

        for (int i = 0; i < 400; i++) begin
            logic [6:0] op;
            op = ops[$urandom_range(0, 8)];
            applyStimulus(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          (op == LOAD) ? 3'($urandom_range(1, 5)) : 3'd0,
                          !(op inside {STORE, BRANCH}),
                          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20);
            cycle("random");
        end

        force dut.bubble_cnt_q = 16'hFFFD;
        #1 release dut.bubble_cnt_q;
        exp_cnt = 65533;
        applyStimulus(LOAD, 5'd5, 5'd5, 5'd0, 3'b001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle("saturate");
        checks++;
        assert (bubble_cnt === 16'hFFFF) else begin
            errors++;
            $error("[TB] FAIL saturate_final bubble_cnt: observed %h expected ffff", bubble_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
